carrier_sense_detector: RTL and testbench
=========================================

CARRIER_SENSE_DETECTOR -- requirements
Module: carrier_sense_detector

Interface
REQ-001 The block SHALL have parameter SETTLE_SAMPLES, default 64, the number of valid samples to discard after reset, enable or own transmission while the averager window refills.
REQ-002 The block SHALL have parameter CNT_W, default 8, the width of the run-length counters and count thresholds.
REQ-003 The block SHALL have parameter BACKOFF_W, default 10, the width of the backoff mask (only used when CS_BACKOFF_EN is defined).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-006 The block SHALL have port average, input, 32 bits, the windowed magnitude sum from the averager, already saturated.
REQ-007 The block SHALL have port average_valid, input, 1 bit, which qualifies average for one cycle per sample.
REQ-008 The block SHALL have ports threshold_hi and threshold_lo, input, 32 bits each, the busy-entry and busy-exit levels.
REQ-009 The block SHALL have ports busy_count and idle_count, input, CNT_W bits each, the consecutive-sample requirements; a value of 0 SHALL be treated as 1.
REQ-010 The block SHALL have port enable, input, 1 bit, which enables detection.
REQ-011 The block SHALL have ports tx_req and tx_done, input, 1 bit each, the transmitter request and end-of-transmission pulse.
REQ-012 The block SHALL have port channel_busy, output, 1 bit, the registered busy indication.
REQ-013 The block SHALL have port tx_grant, output, 1 bit, the registered transmit grant.
REQ-014 The block SHALL have port cs_state, output, 3 bits, the current state encoding: SETTLE=0, IDLE=1, BUSY=2, TX=3, BACKOFF=4.
REQ-015 The block SHALL have port busy_events, output, 16 bits, a saturating count of IDLE->BUSY transitions.

Function
REQ-016 All comparisons SHALL be unsigned 32-bit; "hi sample" means average_valid and average >= threshold_hi; "lo sample" means average_valid and average <= threshold_lo.
REQ-017 In SETTLE, the block SHALL count valid samples; on the valid sample that makes the count equal SETTLE_SAMPLES, with enable high, it SHALL go to IDLE; channel_busy=1 and tx_grant=0.
REQ-018 In IDLE, channel_busy SHALL be 0 and hi_run SHALL increment on each hi sample, clear on any other valid sample, and hold when there is no valid sample.
REQ-019 In IDLE, when hi_run would reach max(busy_count,1), the block SHALL go to BUSY, increment busy_events (saturating at 0xFFFF), and clear hi_run.
REQ-020 In IDLE, with tx_req high and no BUSY transition this cycle, the block SHALL go to TX; a simultaneous busy decision SHALL win.
REQ-021 In BUSY, channel_busy SHALL be 1; lo_run SHALL follow the hi_run rules using lo samples; reaching max(idle_count,1) SHALL exit BUSY per REQ-029/030.
REQ-022 In TX, tx_grant SHALL be 1 and channel_busy SHALL be 1; on tx_done the block SHALL go to SETTLE with the settle counter cleared.
REQ-023 With enable low, any state other than TX SHALL go to SETTLE next cycle and hold there; TX SHALL still complete normally.
REQ-024 tx_req is level-sensitive; it SHALL be ignored outside IDLE, and tx_done SHALL be ignored outside TX.
REQ-025 All outputs SHALL be registered; tx_grant SHALL assert one cycle after the IDLE cycle that samples tx_req.

Reset
REQ-026 On rst_n low, the block SHALL asynchronously enter state SETTLE with all counters cleared.
REQ-027 Reset values SHALL be channel_busy=1, tx_grant=0, cs_state=0 and busy_events=0; reset mid-TX SHALL drop tx_grant immediately.

Configuration
REQ-028 Macro CS_BACKOFF_EN SHALL select random backoff.
REQ-029 When CS_BACKOFF_EN is defined, the BUSY exit SHALL go to BACKOFF and load a down-counter with lfsr[BACKOFF_W-1:0]; the 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL be seeded 0xACE1 at reset and step every cycle.
REQ-030 In BACKOFF, channel_busy SHALL be 1; a hi sample SHALL return to BUSY without counting a busy event; a counter of 0 SHALL go to IDLE; a zero load SHALL go to IDLE the next cycle.
REQ-031 When CS_BACKOFF_EN is not defined, the BUSY exit SHALL go directly to IDLE, there SHALL be no LFSR or BACKOFF logic, and encoding 4 SHALL never appear.

Verification
REQ-032 Reset, enable=1, then 64 valid samples of 0 -> cs_state stays 0 for 63 samples, reaches 1 after the 64th, and channel_busy falls to 0.
REQ-033 In IDLE with threshold_hi=1000 and busy_count=3, drive samples 1200,1200,900,1200,1200,1200 -> BUSY entered only after the 6th sample, and busy_events=1.
REQ-034 In BUSY with threshold_lo=500 and idle_count=2, drive samples 400,400 -> IDLE (macro off), or BACKOFF followed by IDLE after the LFSR count (macro on).
REQ-035 In IDLE with busy_count=1, assert tx_req in the same cycle as a 2000 sample -> BUSY and tx_grant stays 0; a later tx_req in clean IDLE -> grant after 1 cycle, and tx_done -> SETTLE.
REQ-036 Force busy_events to 0xFFFF (via 65535 transitions or a backdoor) then trigger another transition -> busy_events remains 0xFFFF.
REQ-037 Pulse rst_n low mid-TX -> tx_grant=0 and cs_state=0 with no clock edge.

Source files
------------

// File: rtl/carrier_sense_detector.sv
// Carrier-sense state machine: settles after reset/enable, tracks busy/idle runs and arbitrates TX.
// Optional random backoff after busy exit is selected with macro CS_BACKOFF_EN.
module carrier_sense_detector #(
    parameter int SETTLE_SAMPLES = 64,
    parameter int CNT_W          = 8,
    parameter int BACKOFF_W      = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      average,
    input  logic             average_valid,
    input  logic [31:0]      threshold_hi,
    input  logic [31:0]      threshold_lo,
    input  logic [CNT_W-1:0] busy_count,
    input  logic [CNT_W-1:0] idle_count,
    input  logic             enable,
    input  logic             tx_req,
    input  logic             tx_done,
    output logic             channel_busy,
    output logic             tx_grant,
    output logic [2:0]       cs_state,
    output logic [15:0]      busy_events
);

    typedef enum logic [2:0] {
        ST_SETTLE  = 3'd0,
        ST_IDLE    = 3'd1,
        ST_BUSY    = 3'd2,
        ST_TX      = 3'd3,
        ST_BACKOFF = 3'd4
    } state_t;

    localparam int SW = $clog2(SETTLE_SAMPLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_SAMPLES > 1) ? (SETTLE_SAMPLES - 1) : 0);

    state_t             state_r;
    state_t             state_s;
    logic [SW-1:0]      settle_cnt_r;
    logic [CNT_W-1:0]   hi_run_r;
    logic [CNT_W-1:0]   lo_run_r;
    logic [15:0]        busy_events_r;
    logic [CNT_W-1:0]   busy_max_s;
    logic [CNT_W-1:0]   idle_max_s;
    logic               hi_s;
    logic               lo_s;
    logic               settle_hit_s;
    logic               busy_hit_s;
    logic               idle_hit_s;
`ifdef CS_BACKOFF_EN
    logic [15:0]        lfsr_r;
    logic [BACKOFF_W-1:0] backoff_cnt_r;
`endif

    // A zero run requirement behaves as a requirement of one sample.
    assign busy_max_s   = (busy_count == {CNT_W{1'b0}}) ? CNT_W'(1) : busy_count;
    assign idle_max_s   = (idle_count == {CNT_W{1'b0}}) ? CNT_W'(1) : idle_count;
    assign hi_s         = average_valid && (average >= threshold_hi);
    assign lo_s         = average_valid && (average <= threshold_lo);
    assign settle_hit_s = average_valid && (settle_cnt_r == SETTLE_LAST);
    assign busy_hit_s   = hi_s && ((hi_run_r + CNT_W'(1)) == busy_max_s);
    assign idle_hit_s   = lo_s && ((lo_run_r + CNT_W'(1)) == idle_max_s);
    assign busy_events  = busy_events_r;

    // Next-state decision; a busy decision in IDLE takes priority over a transmit request.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_SETTLE: begin
                if (enable && settle_hit_s) state_s = ST_IDLE;
                else                        state_s = ST_SETTLE;
            end
            ST_IDLE: begin
                if (!enable)         state_s = ST_SETTLE;
                else if (busy_hit_s) state_s = ST_BUSY;
                else if (tx_req)     state_s = ST_TX;
                else                 state_s = ST_IDLE;
            end
            ST_BUSY: begin
                if (!enable) begin
                    state_s = ST_SETTLE;
                end else if (idle_hit_s) begin
`ifdef CS_BACKOFF_EN
                    state_s = ST_BACKOFF;
`else
                    state_s = ST_IDLE;
`endif
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_TX: begin
                if (tx_done) state_s = ST_SETTLE;
                else         state_s = ST_TX;
            end
`ifdef CS_BACKOFF_EN
            ST_BACKOFF: begin
                if (!enable)                                  state_s = ST_SETTLE;
                else if (hi_s)                                state_s = ST_BUSY;
                else if (backoff_cnt_r == {BACKOFF_W{1'b0}})  state_s = ST_IDLE;
                else                                          state_s = ST_BACKOFF;
            end
`endif
            default: state_s = ST_SETTLE;
        endcase
    end

    // State, run counters and registered outputs; runs restart whenever the state changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_SETTLE;
            settle_cnt_r  <= {SW{1'b0}};
            hi_run_r      <= {CNT_W{1'b0}};
            lo_run_r      <= {CNT_W{1'b0}};
            busy_events_r <= 16'h0000;
            channel_busy  <= 1'b1;
            tx_grant      <= 1'b0;
            cs_state      <= 3'd0;
        end else begin
            state_r      <= state_s;
            cs_state     <= state_s;
            channel_busy <= (state_s != ST_IDLE);
            tx_grant     <= (state_s == ST_TX);

            if ((state_r != ST_SETTLE) || (state_s != ST_SETTLE) || !enable)
                settle_cnt_r <= {SW{1'b0}};
            else if (average_valid)
                settle_cnt_r <= settle_cnt_r + SW'(1);
            else
                settle_cnt_r <= settle_cnt_r;

            if ((state_r != ST_IDLE) || (state_s != ST_IDLE))
                hi_run_r <= {CNT_W{1'b0}};
            else if (hi_s)
                hi_run_r <= hi_run_r + CNT_W'(1);
            else if (average_valid)
                hi_run_r <= {CNT_W{1'b0}};
            else
                hi_run_r <= hi_run_r;

            if ((state_r != ST_BUSY) || (state_s != ST_BUSY))
                lo_run_r <= {CNT_W{1'b0}};
            else if (lo_s)
                lo_run_r <= lo_run_r + CNT_W'(1);
            else if (average_valid)
                lo_run_r <= {CNT_W{1'b0}};
            else
                lo_run_r <= lo_run_r;

            if ((state_r == ST_IDLE) && (state_s == ST_BUSY) && (busy_events_r != 16'hFFFF))
                busy_events_r <= busy_events_r + 16'd1;
            else
                busy_events_r <= busy_events_r;
        end
    end

`ifdef CS_BACKOFF_EN
    // Free-running Fibonacci LFSR (taps 16,14,13,11) and the backoff down-counter it seeds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r        <= 16'hACE1;
            backoff_cnt_r <= {BACKOFF_W{1'b0}};
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
            if ((state_r == ST_BUSY) && (state_s == ST_BACKOFF))
                backoff_cnt_r <= lfsr_r[BACKOFF_W-1:0];
            else if ((state_r == ST_BACKOFF) && (backoff_cnt_r != {BACKOFF_W{1'b0}}))
                backoff_cnt_r <= backoff_cnt_r - BACKOFF_W'(1);
            else
                backoff_cnt_r <= backoff_cnt_r;
        end
    end
`endif

endmodule

// File: tb/tb_carrier_sense_detector.sv
// Directed and randomized checks of carrier_sense_detector against a behavioural model.
module tb_carrier_sense_detector;

    localparam int SETTLE = 64;
    localparam int BW     = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] average;
    logic        average_valid;
    logic [31:0] threshold_hi;
    logic [31:0] threshold_lo;
    logic [7:0]  busy_count;
    logic [7:0]  idle_count;
    logic        enable;
    logic        tx_req;
    logic        tx_done;
    logic        channel_busy;
    logic        tx_grant;
    logic [2:0]  cs_state;
    logic [15:0] busy_events;

    int compared   = 0;
    int mismatched = 0;

    int m_state, m_settle, m_hi, m_lo, m_events, m_lfsr, m_bo;

    carrier_sense_detector #(.SETTLE_SAMPLES(SETTLE), .CNT_W(8), .BACKOFF_W(BW)) dut (
        .clk(clk), .rst_n(rst_n), .average(average), .average_valid(average_valid),
        .threshold_hi(threshold_hi), .threshold_lo(threshold_lo),
        .busy_count(busy_count), .idle_count(idle_count), .enable(enable),
        .tx_req(tx_req), .tx_done(tx_done), .channel_busy(channel_busy),
        .tx_grant(tx_grant), .cs_state(cs_state), .busy_events(busy_events)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_settle = 0; m_hi = 0; m_lo = 0; m_events = 0; m_bo = 0;
        m_lfsr = 16'hACE1;
    endtask

    // Behavioural model: one clock of the carrier-sense rules using plain integers.
    task automatic model_step();
        int  nxt, bmax, imax;
        bit  hi, lo;
        hi   = average_valid && (average >= threshold_hi);
        lo   = average_valid && (average <= threshold_lo);
        bmax = (busy_count == 0) ? 1 : int'(busy_count);
        imax = (idle_count == 0) ? 1 : int'(idle_count);
        nxt  = m_state;
        case (m_state)
            0: begin
                if (!enable) m_settle = 0;
                else if (average_valid) begin
                    m_settle++;
                    if (m_settle == SETTLE) nxt = 1;
                end
            end
            1: begin
                if (!enable) nxt = 0;
                else begin
                    if (hi) begin
                        m_hi++;
                        if (m_hi == bmax) begin
                            nxt = 2;
                            if (m_events < 65535) m_events++;
                        end
                    end else if (average_valid) m_hi = 0;
                    if (nxt == 1 && tx_req) nxt = 3;
                end
            end
            2: begin
                if (!enable) nxt = 0;
                else if (lo) begin
                    m_lo++;
                    if (m_lo == imax) begin
`ifdef CS_BACKOFF_EN
                        nxt  = 4;
                        m_bo = m_lfsr % (1 << BW);
`else
                        nxt = 1;
`endif
                    end
                end else if (average_valid) m_lo = 0;
            end
            3: if (tx_done) nxt = 0;
            4: begin
                if (!enable) nxt = 0;
                else if (hi) nxt = 2;
                else if (m_bo == 0) nxt = 1;
                else m_bo--;
            end
            default: nxt = 0;
        endcase
        if (nxt != m_state) begin
            m_hi = 0; m_lo = 0; m_settle = 0;
        end
        m_lfsr  = ((m_lfsr << 1) | (((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1)) & 16'hFFFF;
        m_state = nxt;
    endtask

    task automatic check_all();
        chk("cs_state", {29'd0, cs_state}, m_state);
        chk("channel_busy", {31'd0, channel_busy}, {31'd0, m_state != 1});
        chk("tx_grant", {31'd0, tx_grant}, {31'd0, m_state == 3});
        chk("busy_events", {16'd0, busy_events}, m_events);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input int avg, input bit v);
        average       = avg;
        average_valid = v;
        step();
    endtask

    task automatic settle_up();
        for (int i = 0; i < SETTLE; i++) drive(0, 1'b1);
    endtask

    // Spend idle cycles while the model sits in backoff, bounded by the largest possible count.
    task automatic drain_backoff();
        for (int i = 0; i < 1100 && m_state == 4; i++) drive(0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; tx_req = 1'b0; tx_done = 1'b0;
        average = 32'd0; average_valid = 1'b0;
        threshold_hi = 32'd1000; threshold_lo = 32'd500;
        busy_count = 8'd3; idle_count = 8'd2;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", {29'd0, cs_state}, 32'd0);
        chk("rst_busy", {31'd0, channel_busy}, 32'd1);
        chk("rst_grant", {31'd0, tx_grant}, 32'd0);
        chk("rst_events", {16'd0, busy_events}, 32'd0);
        rst_n = 1'b1;

        // Settle: 63 samples keep SETTLE, the 64th reaches IDLE.
        enable = 1'b1;
        for (int i = 0; i < SETTLE - 1; i++) drive(0, 1'b1);
        chk("settle_hold", {29'd0, cs_state}, 32'd0);
        drive(0, 1'b1);
        chk("settle_done", {29'd0, cs_state}, 32'd1);
        chk("settle_busy_low", {31'd0, channel_busy}, 32'd0);

        // Busy entry needs three consecutive hi samples.
        drive(1200, 1'b1); drive(1200, 1'b1); drive(900, 1'b1);
        drive(1200, 1'b1); drive(1200, 1'b1);
        chk("busy_not_yet", {29'd0, cs_state}, 32'd1);
        drive(1200, 1'b1);
        chk("busy_entered", {29'd0, cs_state}, 32'd2);
        chk("busy_events_1", {16'd0, busy_events}, 32'd1);

        // Busy exit after two lo samples.
        drive(400, 1'b1); drive(400, 1'b1);
        drain_backoff();
        chk("busy_exit", {29'd0, cs_state}, 32'd1);

        // Busy beats a simultaneous tx_req; later a clean request is granted.
        busy_count = 8'd1;
        tx_req = 1'b1;
        drive(2000, 1'b1);
        chk("busy_wins", {29'd0, cs_state}, 32'd2);
        chk("busy_wins_grant", {31'd0, tx_grant}, 32'd0);
        tx_req = 1'b0;
        drive(400, 1'b1); drive(400, 1'b1);
        drain_backoff();
        tx_req = 1'b1;
        drive(0, 1'b0);
        chk("grant_1cyc", {31'd0, tx_grant}, 32'd1);
        tx_req = 1'b0;
        repeat (3) drive(0, 1'b0);
        tx_done = 1'b1;
        drive(0, 1'b0);
        tx_done = 1'b0;
        chk("tx_done_settle", {29'd0, cs_state}, 32'd0);

        // Asynchronous reset in the middle of a transmission.
        settle_up();
        tx_req = 1'b1;
        drive(0, 1'b0);
        tx_req = 1'b0;
        drive(0, 1'b0);
        chk("in_tx", {29'd0, cs_state}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_grant", {31'd0, tx_grant}, 32'd0);
        chk("async_state", {29'd0, cs_state}, 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Saturation of the busy event counter.
        settle_up();
        idle_count = 8'd1;
        force dut.busy_events_r = 16'hFFFE;
        #1 release dut.busy_events_r;
        m_events = 65534;
        drive(2000, 1'b1);
        chk("events_ffff", {16'd0, busy_events}, 32'h0000FFFF);
        drive(400, 1'b1);
        drain_backoff();
        drive(2000, 1'b1);
        chk("events_saturate", {16'd0, busy_events}, 32'h0000FFFF);
        chk("sat_state", {29'd0, cs_state}, 32'd2);

        // Randomized traffic around the thresholds.
        for (int i = 0; i < 6000; i++) begin
            enable        = ($urandom_range(0, 199) != 0);
            tx_req        = ($urandom_range(0, 29) == 0);
            tx_done       = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 49) == 0) busy_count = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) idle_count = 8'($urandom_range(0, 3));
            drive(int'($urandom_range(0, 1500)), ($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
